fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side drain engine for the async FIFO, single clock domain rd_clk.
//  Issues FIFO reads, captures the 1-cycle-latency registered dout/valid
//  into a small skid buffer, and presents words as a valid/ready stream.
//  Also provides a burst-boundary flag (m_last) and a delivered-word counter.
// PARAMETERS
//  DATA_WIDTH  16  word width; must match the FIFO data_width
//  BUF_DEPTH   4   skid buffer entries (>=2); covers FIFO read latency
//  BURST_LEN   8   beats per burst; m_last marks beat BURST_LEN-1 (>=1)
//  CNT_WIDTH   16  width of word_cnt
// PORTS
//  rd_clk      in   1           clock, shared with the FIFO read side
//  rst         in   1           async active-high reset
//  en          in   1           1 = fetch from FIFO; 0 = stop fetching and drain
//  fifo_empty  in   1           FIFO empty flag (read domain)
//  fifo_valid  in   1           FIFO read data valid, 1 cycle after accepted rd_en
//  fifo_dout   in   DATA_WIDTH  FIFO read data, meaningful only when fifo_valid=1
//  fifo_rd_en  out  1           FIFO read request (combinational)
//  m_data      out  DATA_WIDTH  stream data (buffer head)
//  m_valid     out  1           stream valid
//  m_ready     in   1           stream ready from consumer
//  m_last      out  1           current beat closes a burst
//  busy        out  1           state != IDLE
//  word_cnt    out  CNT_WIDTH   number of completed m transfers, wraps modulo 2^CNT_WIDTH
//  ovf_err     out  1           sticky: fifo_valid arrived while buffer full
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; occ=0; inflight=0; beat_cnt=0;
//   word_cnt=0; ovf_err=0; m_data=0; m_valid=0; m_last=0; busy=0.
//   fifo_rd_en is forced to 0 while rst=1.
//   Words in flight or buffered at reset are discarded.
//  FSM:
//   IDLE->RUN when en=1.
//   RUN->DRAIN when en=0.
//   DRAIN->RUN when en=1.
//   DRAIN->IDLE when inflight=0 and occ=0.
//  fifo_rd_en = (state==RUN) & ~fifo_empty & (occ + inflight < BUF_DEPTH).
//   Never asserted when fifo_empty=1.
//  inflight is a register: inflight <= fifo_rd_en, updated every cycle.
//  Capture: on fifo_valid=1, fifo_dout is pushed at the buffer tail.
//   If occ==BUF_DEPTH (not reachable in correct operation), the word is
//   dropped and ovf_err is set; ovf_err stays 1 until rst.
//  Latency: fifo_rd_en=1 in cycle 0 -> fifo_valid=1 in cycle 1
//   -> m_valid=1 in cycle 2 (fifo_valid to m_valid: 1 cycle).
//  Stream side:
//   m_valid = (occ != 0); m_data = head entry; m_data=0 when occ=0.
//   Transfer = m_valid & m_ready; the head pops on the same edge.
//   While m_valid=1 and m_ready=0, m_data and m_last hold stable.
//   Simultaneous push and pop: occ unchanged; order preserved (FIFO order).
//   Pointers wrap modulo BUF_DEPTH.
//  Burst: m_last = m_valid & (beat_cnt == BURST_LEN-1).
//   On transfer, beat_cnt increments, wrapping to 0 after BURST_LEN-1.
//   beat_cnt is not cleared by en=0.
//  word_cnt increments by 1 on each transfer.
//  Throughput: with m_ready held at 1 and the FIFO non-empty, one word per cycle.
// TESTING
//  1 Reset, then en=1, FIFO holds words 0x0001..0x0003, m_ready=1
//    -> m_data 1,2,3 on consecutive cycles; first m_valid 2 cycles after first rd_en;
//    word_cnt=3.
//  2 m_ready=0 with 10 words available -> fifo_rd_en stops once occ+inflight=4;
//    m_data stays at the first word; no ovf_err.
//  3 Burst: 16 transfers with BURST_LEN=8 -> m_last=1 exactly on transfers 8 and 16.
//  4 en->0 with 1 read in flight -> state DRAIN; word captured and delivered;
//    then IDLE, busy=0, no further fifo_rd_en.
//  5 rst pulse mid-stream with occ=3 -> all outputs 0 immediately;
//    after release, m_valid=0 until new reads complete.
//  6 Random m_ready with 1000 words -> output sequence equals input sequence;
//    word_cnt=1000 (mod 2^16); fifo_rd_en never 1 while fifo_empty=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the FIFO read port into a skid buffer and presents it as a valid/ready stream
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  ovf_err
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic [BW-1:0] beat_cnt;
  logic inflight, push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    state_nx = en ? RUN
             : state == RUN ? DRAIN
             : (state == DRAIN && (inflight || occ != '0)) ? DRAIN
             : IDLE;
  end
  // reads in flight reserve buffer space so a returning word always has a slot
  assign fifo_rd_en = !rst && state == RUN && !fifo_empty &&
                      (32'(occ) + 32'(inflight) < 32'(BUF_DEPTH));
  assign push     = fifo_valid && occ != OW'(BUF_DEPTH);
  assign m_valid  = occ != '0;
  assign pop      = m_valid && m_ready;
  assign m_data   = m_valid ? mem[rd_ptr] : '0;
  assign m_last   = m_valid && beat_cnt == BW'(BURST_LEN - 1);
  assign busy     = state != IDLE;
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      occ      <= '0;
      inflight <= 1'b0;
      beat_cnt <= '0;
      word_cnt <= '0;
      ovf_err  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nx;
      inflight <= fifo_rd_en;
      occ      <= occ + OW'(push) - OW'(pop);
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) begin
        rd_ptr   <= inc(rd_ptr);
        beat_cnt <= beat_cnt == BW'(BURST_LEN - 1) ? '0 : beat_cnt + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      if (fifo_valid && !push) ovf_err <= 1'b1;
    end
  end
  always_ff @(posedge rd_clk) begin
    if (push) mem[wr_ptr] <= fifo_dout;
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a behavioural 1-cycle-latency FIFO feeding the drain engine
module tb_fifo_rd_stream;
  logic        rd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_valid = 1'b0;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty, fifo_rd_en, m_valid, m_last, busy, ovf_err;
  logic [15:0] m_data, word_cnt;
  logic [15:0] src [2048];
  int pushed = 0;
  int popped = 0;
  int n_cmp = 0;
  int n_bad = 0;

  fifo_rd_stream #(.DATA_WIDTH(16), .BUF_DEPTH(4), .BURST_LEN(8), .CNT_WIDTH(16)) dut (
    .rd_clk(rd_clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .word_cnt(word_cnt), .ovf_err(ovf_err)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (pushed == popped);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_dout  <= src[popped];
      popped     <= popped + 1;
      fifo_valid <= 1'b1;
    end else begin
      fifo_valid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    src[pushed] = w;
    pushed++;
  endtask

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    logic        found;
    int          cnt, n, got, bad, viol;
    logic [15:0] exp_w;
    repeat (2) @(negedge rd_clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_ovf", ovf_err, 0);
    for (int i = 1; i <= 3; i++) push_word(16'(i));
    #1 chk("rst_rd_en_forced", fifo_rd_en, 0);
    // test 1: three words, latency and back-to-back delivery
    @(negedge rd_clk);
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge rd_clk);
      found = fifo_rd_en;
    end
    chk("t1_rd_en_seen", found, 1);
    @(negedge rd_clk) chk("t1_valid_lat1", m_valid, 0);
    @(negedge rd_clk) chk("t1_valid_lat2", m_valid, 1);
    chk("t1_data1", m_data, 16'h0001);
    @(negedge rd_clk) chk("t1_data2", m_data, 16'h0002);
    @(negedge rd_clk) chk("t1_data3", m_data, 16'h0003);
    @(negedge rd_clk) chk("t1_valid_end", m_valid, 0);
    chk("t1_word_cnt", word_cnt, 3);
    // test 2: backpressure with 10 words available
    m_ready = 1'b0;
    for (int i = 4; i <= 13; i++) push_word(16'(i));
    #1 cnt = 0;
    repeat (8) begin
      cnt += int'(fifo_rd_en);
      @(negedge rd_clk);
      #1;
    end
    chk("t2_rd_count", cnt, 4);
    chk("t2_rd_en_off", fifo_rd_en, 0);
    chk("t2_valid", m_valid, 1);
    chk("t2_data_hold", m_data, 16'h0004);
    chk("t2_ovf", ovf_err, 0);
    chk("t2_fifo_reads", popped, 7);
    chk("t2_last", m_last, 0);
    // test 5: reset pulse with occ=3
    m_ready = 1'b1;
    @(negedge rd_clk);
    m_ready = 1'b0;
    #1 chk("t5_pre_rd_en", fifo_rd_en, 1);
    chk("t5_pre_data", m_data, 16'h0005);
    chk("t5_pre_cnt", word_cnt, 4);
    rst = 1'b1;
    #1 chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_m_last", m_last, 0);
    chk("t5_busy", busy, 0);
    chk("t5_word_cnt", word_cnt, 0);
    chk("t5_rd_en", fifo_rd_en, 0);
    en = 1'b0;
    repeat (2) @(negedge rd_clk);
    rst = 1'b0;
    for (int i = 14; i <= 23; i++) push_word(16'(i));
    @(negedge rd_clk);
    chk("t5_idle_valid", m_valid, 0);
    chk("t5_idle_busy", busy, 0);
    en = 1'b1; m_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge rd_clk);
      found = fifo_rd_en;
    end
    chk("t5_rd_en_seen", found, 1);
    @(negedge rd_clk) chk("t5_valid_wait", m_valid, 0);
    @(negedge rd_clk) chk("t5_first_valid", m_valid, 1);
    // test 3: 16 transfers, m_last on transfers 8 and 16
    n = 0; exp_w = 16'h0008;
    for (int c = 0; c < 60 && n < 16; c++) begin
      if (m_valid && m_ready) begin
        n++;
        chk("t3_data", m_data, exp_w);
        chk("t3_last", m_last, (n % 8) == 0);
        exp_w++;
      end
      @(negedge rd_clk);
    end
    chk("t3_transfers", n, 16);
    chk("t3_word_cnt", word_cnt, 16);
    // test 4: drop en with one read in flight
    push_word(16'h00AA);
    en = 1'b0;
    #1 chk("t4_rd_en", fifo_rd_en, 1);
    @(negedge rd_clk);
    chk("t4_busy_drain", busy, 1);
    chk("t4_rd_en_off", fifo_rd_en, 0);
    chk("t4_valid0", m_valid, 0);
    @(negedge rd_clk);
    chk("t4_valid1", m_valid, 1);
    chk("t4_data", m_data, 16'h00AA);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge rd_clk);
      found = !busy;
    end
    chk("t4_idle", found, 1);
    chk("t4_word_cnt", word_cnt, 17);
    for (int i = 0; i < 1000; i++) push_word(16'($urandom));
    #1 cnt = 0;
    repeat (3) begin
      cnt += int'(fifo_rd_en);
      @(negedge rd_clk);
      #1;
    end
    chk("t4_no_rd_idle", cnt, 0);
    chk("t4_busy_idle", busy, 0);
    // test 6: 1000 words under random backpressure
    rst = 1'b1;
    @(negedge rd_clk);
    rst = 1'b0;
    #1 chk("t6_cnt_reset", word_cnt, 0);
    en = 1'b1;
    got = 0; bad = 0; viol = 0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      @(negedge rd_clk);
      m_ready = ($urandom_range(0, 1) != 0);
      #1;
      if (fifo_rd_en && fifo_empty) viol++;
      if (m_valid && m_ready) begin
        if (m_data !== src[24 + got]) bad++;
        got++;
      end
    end
    @(negedge rd_clk);
    chk("t6_delivered", got, 1000);
    chk("t6_seq_errors", bad, 0);
    chk("t6_rd_when_empty", viol, 0);
    chk("t6_word_cnt", word_cnt, 1000);
    chk("t6_ovf", ovf_err, 0);
    en = 1'b0; m_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge rd_clk);
      found = !busy;
    end
    chk("t6_idle", found, 1);
    chk("t6_valid_end", m_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
